// File: rtl/hub75_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hub75_fb_arbiter
// Brief    : Shares one single-port framebuffer RAM between HUB75 display
//            reads (priority) and host pixel writes. A starvation counter
//            guarantees write progress. Double-buffer swaps are applied only
//            on the frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_fb_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 24,
  parameter int STARVE_MAX = 8
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              swap_req_i,
  input  logic              frame_end_i,
  output logic              swap_pending_o,
  output logic              disp_buf_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // A zero limit still needs a one-bit counter so the compare stays legal.
  localparam int              CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               disp_buf_q, disp_buf_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               mem_re_q, mem_we_q;
  logic [ADDR_W:0]    mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               rd_valid_q;

  logic               swap_pending;
  logic               force_wr;
  logic               wr_acc;

  assign swap_pending = (state_q == ST_PENDING);
  assign force_wr     = wr_valid_i && !swap_pending && (starve_q == CNT_MAX);
  assign rd_gnt_o     = rd_req_i && !force_wr;
  assign wr_ready_o   = !swap_pending && (!rd_req_i || force_wr);
  assign wr_acc       = wr_valid_i && wr_ready_o;

  // Swap FSM: request parks in PENDING until the frame boundary toggles the buffer.
  always_comb begin
    state_d    = state_q;
    disp_buf_d = disp_buf_q;
    case (state_q)
      ST_RUN: begin
        if (swap_req_i) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_end_i) begin
          state_d    = ST_RUN;
          disp_buf_d = ~disp_buf_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Starvation counter: counts cycles a write is blocked by reads, frozen during a swap.
  always_comb begin
    starve_d = starve_q;
    if (!swap_pending) begin
      if (!wr_valid_i || wr_acc) begin
        starve_d = '0;
      end else if (starve_q != CNT_MAX) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  // Swap state, buffer select and starvation count registers.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      disp_buf_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      disp_buf_q <= disp_buf_d;
      starve_q   <= starve_d;
    end
  end

  // Register the grant into the RAM command; buffer select is taken in the grant cycle.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      mem_re_q   <= rd_gnt_o;
      mem_we_q   <= wr_acc;
      rd_valid_q <= mem_re_q;
      if (rd_gnt_o) begin
        mem_addr_q <= {disp_buf_q, rd_addr_i};
      end else if (wr_acc) begin
        mem_addr_q  <= {~disp_buf_q, wr_addr_i};
        mem_wdata_q <= wr_data_i;
      end
    end
  end

  // The RAM output is already registered; it is presented in the cycle after mem_re
  // and masked to zero otherwise so rd_data reads zero out of reset.
  assign rd_data_o      = rd_valid_q ? mem_rdata_i : '0;
  assign rd_valid_o     = rd_valid_q;
  assign swap_pending_o = swap_pending;
  assign disp_buf_o     = disp_buf_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_we_o       = mem_we_q;
  assign mem_re_o       = mem_re_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_fb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hub75_fb_arbiter
// Brief    : Self-checking bench for hub75_fb_arbiter with a RAM model and a
//            cycle-level reference of the arbitration and swap rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_fb_arbiter;
  localparam int AW = 13;
  localparam int DW = 24;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rd_req, wr_valid, swap_req, frame_end;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_gnt, rd_valid, wr_ready, swap_pending, disp_buf, mem_we, mem_re;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW:0]   mem_addr;

  logic          rd_gnt0, rd_valid0, wr_ready0, swap_pending0, disp_buf0, mem_we0, mem_re0;
  logic [DW-1:0] rd_data0, mem_wdata0, mem_rdata0;
  logic [AW:0]   mem_addr0;

  logic [DW-1:0] ram  [0:(1<<(AW+1))-1];
  logic [DW-1:0] ram0 [0:(1<<(AW+1))-1];

  int checks = 0;
  int failures = 0;
  logic [AW:0] exp_addr_hold;

  hub75_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .swap_req_i(swap_req), .frame_end_i(frame_end), .swap_pending_o(swap_pending),
    .disp_buf_o(disp_buf), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata));

  hub75_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(0)) dut0 (
    .sys_clk_i(clk), .rst_n_i(rst_n), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_gnt_o(rd_gnt0), .rd_valid_o(rd_valid0), .rd_data_o(rd_data0),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready0),
    .swap_req_i(swap_req), .frame_end_i(frame_end), .swap_pending_o(swap_pending0),
    .disp_buf_o(disp_buf0), .mem_addr_o(mem_addr0), .mem_wdata_o(mem_wdata0),
    .mem_we_o(mem_we0), .mem_re_o(mem_re0), .mem_rdata_i(mem_rdata0));

  // Synchronous single-port RAM models: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
    if (mem_re0) mem_rdata0 <= ram0[mem_addr0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_req = 1'b1; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; swap_req = 1'b0; frame_end = 1'b0;
    step(); step();
    checks++;
    if ({mem_re, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, disp_buf, swap_pending} !== '0) begin
      failures++;
      $display("FAIL reset_regs got re=%b we=%b addr=%h wd=%h rv=%b rd=%h db=%b sp=%b exp all zero",
               mem_re, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, disp_buf, swap_pending);
    end
    checks++;
    if (rd_gnt !== 1'b1 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL reset_comb_rd got gnt=%b rdy=%b exp gnt=1 rdy=0", rd_gnt, wr_ready);
    end
    rd_req = 1'b0; #1;
    checks++;
    if (rd_gnt !== 1'b0 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_comb_idle got gnt=%b rdy=%b exp gnt=0 rdy=1", rd_gnt, wr_ready);
    end
    rd_req = 1'b1; #1;
  endtask

  task automatic test_read_stream();
    logic [AW-1:0] a [0:39];
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a[k] = (k < 16) ? AW'(k) : AW'($urandom);
      rd_req = 1'b1; rd_addr = a[k];
      #1;
      checks++;
      if (rd_gnt !== 1'b1) begin
        failures++; $display("FAIL rd_stream_gnt k=%0d got=%b exp=1", k, rd_gnt);
      end
      if (k < 2) begin
        checks++;
        if (rd_valid !== 1'b0) begin
          failures++; $display("FAIL rd_stream_early_valid k=%0d got=%b exp=0", k, rd_valid);
        end
      end
      step();
      checks++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {1'b0, a[k]}) begin
        failures++;
        $display("FAIL rd_stream_cmd k=%0d got re=%b we=%b addr=%h exp re=1 we=0 addr=%h",
                 k, mem_re, mem_we, mem_addr, {1'b0, a[k]});
      end
      if (k >= 1) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== ram[{1'b0, a[k-1]}]) begin
          failures++;
          $display("FAIL rd_stream_data k=%0d got v=%b d=%h exp v=1 d=%h",
                   k, rd_valid, rd_data, ram[{1'b0, a[k-1]}]);
        end
      end
    end
    exp_addr_hold = {1'b0, a[39]};
    rd_req = 1'b0;
    step(); step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++; $display("FAIL rd_stream_drain got=%b exp=0", rd_valid);
    end
  endtask

  // Random mix of reads and writes against a rule-level reference (no swaps).
  task automatic test_random_mix();
    int blocked = 0;
    logic prev_g = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic e_force, e_acc, e_gnt;
    for (int k = 0; k < 300; k++) begin
      rd_req   = ($urandom_range(0, 3) != 0);
      wr_valid = ($urandom_range(0, 2) != 0);
      rd_addr  = AW'($urandom);
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      e_force  = wr_valid && (blocked >= SMAX);
      e_gnt    = rd_req && !e_force;
      e_acc    = wr_valid && (!rd_req || e_force);
      #1;
      checks++;
      if (rd_gnt !== e_gnt || wr_ready !== (!rd_req || e_force)) begin
        failures++;
        $display("FAIL mix_arb k=%0d got gnt=%b rdy=%b exp gnt=%b rdy=%b",
                 k, rd_gnt, wr_ready, e_gnt, (!rd_req || e_force));
      end
      step();
      if (e_gnt) exp_addr_hold = {1'b0, rd_addr};
      else if (e_acc) exp_addr_hold = {1'b1, wr_addr};
      checks++;
      if (mem_re !== e_gnt || mem_we !== e_acc || mem_addr !== exp_addr_hold ||
          (e_acc && mem_wdata !== wr_data)) begin
        failures++;
        $display("FAIL mix_cmd k=%0d got re=%b we=%b addr=%h wd=%h exp re=%b we=%b addr=%h wd=%h",
                 k, mem_re, mem_we, mem_addr, mem_wdata, e_gnt, e_acc, exp_addr_hold, wr_data);
      end
      checks++;
      if (rd_valid !== prev_g || (prev_g && rd_data !== ram[{1'b0, prev_a}])) begin
        failures++;
        $display("FAIL mix_rdata k=%0d got v=%b d=%h exp v=%b d=%h",
                 k, rd_valid, rd_data, prev_g, ram[{1'b0, prev_a}]);
      end
      blocked = (!wr_valid || e_acc) ? 0 : blocked + 1;
      prev_g = e_gnt;
      prev_a = rd_addr;
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_starve();
    int writes = 0;
    logic exp_w;
    for (int k = 0; k < 45; k++) begin
      rd_req = 1'b1; wr_valid = 1'b1;
      rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      exp_w = ((k % (SMAX + 1)) == SMAX);
      #1;
      checks++;
      if (wr_ready !== exp_w || rd_gnt !== !exp_w) begin
        failures++;
        $display("FAIL starve_arb k=%0d got rdy=%b gnt=%b exp rdy=%b gnt=%b",
                 k, wr_ready, rd_gnt, exp_w, !exp_w);
      end
      step();
      checks++;
      if (mem_we !== exp_w || mem_re !== !exp_w ||
          mem_addr !== (exp_w ? {1'b1, wr_addr} : {1'b0, rd_addr}) ||
          (exp_w && mem_wdata !== wr_data)) begin
        failures++;
        $display("FAIL starve_cmd k=%0d got we=%b re=%b addr=%h wd=%h exp we=%b", k, mem_we,
                 mem_re, mem_addr, mem_wdata, exp_w);
      end
      if (mem_we === 1'b1) writes++;
    end
    checks++;
    if (writes != 5) begin
      failures++; $display("FAIL starve_count got=%0d exp=5", writes);
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    step();
  endtask

  task automatic test_swap();
    logic [AW-1:0] ra;
    swap_req = 1'b1; rd_req = 1'b0; wr_valid = 1'b1; wr_addr = AW'($urandom);
    #1;
    checks++;
    if (wr_ready !== 1'b1 || swap_pending !== 1'b0) begin
      failures++; $display("FAIL swap_req_cycle got rdy=%b sp=%b exp rdy=1 sp=0", wr_ready, swap_pending);
    end
    step();
    for (int k = 0; k < 20; k++) begin
      swap_req = (k == 5);
      rd_req   = k[0];
      rd_addr  = AW'($urandom);
      wr_valid = 1'b1;
      #1;
      checks++;
      if (swap_pending !== 1'b1 || wr_ready !== 1'b0 || rd_gnt !== rd_req || disp_buf !== 1'b0) begin
        failures++;
        $display("FAIL swap_pending k=%0d got sp=%b rdy=%b gnt=%b db=%b exp sp=1 rdy=0 gnt=%b db=0",
                 k, swap_pending, wr_ready, rd_gnt, disp_buf, rd_req);
      end
      step();
      checks++;
      if (mem_we !== 1'b0 || (rd_req && mem_addr !== {1'b0, rd_addr})) begin
        failures++;
        $display("FAIL swap_pending_cmd k=%0d got we=%b addr=%h", k, mem_we, mem_addr);
      end
    end
    swap_req = 1'b0; frame_end = 1'b1; rd_req = 1'b1; wr_valid = 1'b0;
    ra = AW'($urandom); rd_addr = ra;
    step();
    frame_end = 1'b0;
    checks++;
    if (disp_buf !== 1'b1 || swap_pending !== 1'b0 || mem_addr !== {1'b0, ra}) begin
      failures++;
      $display("FAIL swap_apply got db=%b sp=%b addr=%h exp db=1 sp=0 addr=%h",
               disp_buf, swap_pending, mem_addr, {1'b0, ra});
    end
    ra = AW'($urandom); rd_addr = ra;
    step();
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== {1'b1, ra}) begin
      failures++; $display("FAIL swap_new_rd got re=%b addr=%h exp re=1 addr=%h", mem_re, mem_addr, {1'b1, ra});
    end
    rd_req = 1'b0; wr_valid = 1'b1; wr_addr = AW'($urandom); wr_data = DW'($urandom);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL swap_rdy_back got=%b exp=1", wr_ready);
    end
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== {1'b0, wr_addr}) begin
      failures++; $display("FAIL swap_new_wr got we=%b addr=%h exp we=1 addr=%h", mem_we, mem_addr, {1'b0, wr_addr});
    end
    wr_valid = 1'b0; frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    checks++;
    if (disp_buf !== 1'b1 || swap_pending !== 1'b0) begin
      failures++; $display("FAIL swap_fe_in_run got db=%b sp=%b exp db=1 sp=0", disp_buf, swap_pending);
    end
  endtask

  task automatic test_swap_same_cycle();
    swap_req = 1'b1; frame_end = 1'b1;
    step();
    swap_req = 1'b0; frame_end = 1'b0;
    checks++;
    if (disp_buf !== 1'b1 || swap_pending !== 1'b1) begin
      failures++; $display("FAIL same_cycle got db=%b sp=%b exp db=1 sp=1", disp_buf, swap_pending);
    end
    step(); step();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    checks++;
    if (disp_buf !== 1'b0 || swap_pending !== 1'b0) begin
      failures++; $display("FAIL same_cycle_apply got db=%b sp=%b exp db=0 sp=0", disp_buf, swap_pending);
    end
  endtask

  task automatic test_starve_zero();
    for (int k = 0; k < 10; k++) begin
      rd_req = 1'b1; wr_valid = 1'b1;
      rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      #1;
      checks++;
      if (rd_gnt0 !== 1'b0 || wr_ready0 !== 1'b1) begin
        failures++; $display("FAIL zero_arb k=%0d got gnt=%b rdy=%b exp gnt=0 rdy=1", k, rd_gnt0, wr_ready0);
      end
      step();
      checks++;
      if (mem_we0 !== 1'b1 || mem_re0 !== 1'b0 || mem_addr0 !== {~disp_buf0, wr_addr} ||
          mem_wdata0 !== wr_data || disp_buf0 !== 1'b0) begin
        failures++;
        $display("FAIL zero_cmd k=%0d got we=%b re=%b addr=%h wd=%h exp we=1 re=0 addr=%h wd=%h",
                 k, mem_we0, mem_re0, mem_addr0, mem_wdata0, {1'b1, wr_addr}, wr_data);
      end
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    frame_end = 1'b1; step(); frame_end = 1'b0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    checks++;
    if (disp_buf !== 1'b1 || swap_pending !== 1'b1) begin
      failures++; $display("FAIL mid_setup got db=%b sp=%b exp db=1 sp=1", disp_buf, swap_pending);
    end
    rd_req = 1'b1; rd_addr = AW'($urandom);
    step();
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_re !== 1'b0 || rd_valid !== 1'b0 || disp_buf !== 1'b0 || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got re=%b rv=%b db=%b sp=%b exp all 0", mem_re, rd_valid, disp_buf, swap_pending);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++; $display("FAIL mid_reset_valid k=%0d got=%b exp=0", k, rd_valid);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (rd_valid !== 1'b0 || swap_pending !== 1'b0 || disp_buf !== 1'b0) begin
      failures++; $display("FAIL mid_release got rv=%b sp=%b db=%b exp 0", rd_valid, swap_pending, disp_buf);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW + 1)); i++) begin
      ram[i]  = DW'($urandom);
      ram0[i] = DW'($urandom);
    end
    mem_rdata  = '0;
    mem_rdata0 = '0;
    exp_addr_hold = '0;
    test_reset();
    test_read_stream();
    test_random_mix();
    test_starve();
    test_swap();
    test_swap_same_cycle();
    test_starve_zero();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exceeded 200000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
